mag_arb_sched: RTL and testbench

MAG_ARB_SCHED -- requirements
Module: mag_arb_sched

---
 rtl/mag_arb_sched.sv | 150 +++++++++++++++
 tb/tb_mag_arb_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_arb_sched.sv
// mag_arb_sched
// Two-requester round-robin front end for one shared magnitude engine.
// A granted request is launched on the engine with a one-cycle eng_start.
// The block then waits for eng_done, or gives up after TIMEOUT engine
// cycles, and presents one response that is held until it is accepted.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid[1:0]        per-requester request valid
//   req_x/req_y[15:0]     operands, [7:0] requester 0, [15:8] requester 1
//   req_ready[1:0]        per-requester accept (combinational, IDLE only)
//   eng_start             one-cycle launch pulse to the engine
//   eng_x/eng_y[7:0]      operands held for the engine
//   eng_done, eng_result  engine completion pulse and result
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_data      owning requester and result (0xFF on timeout)
//   rsp_err               1 = engine timed out
//   busy                  high whenever an operation is in flight
module mag_arb_sched #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  output logic [1:0]  req_ready,
  output logic        eng_start,
  output logic [7:0]  eng_x,
  output logic [7:0]  eng_y,
  input  logic        eng_done,
  input  logic [7:0]  eng_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  // Last WAIT cycle index before the engine is declared dead.
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       ptr_reg;
  logic [7:0] cnt_reg;
  logic [7:0] x_reg;
  logic [7:0] y_reg;
  logic       id_reg;
  logic [7:0] data_reg;
  logic       err_reg;

  logic [7:0] req_x_arr [2];
  logic [7:0] req_y_arr [2];
  logic       grant_id;
  logic       handshake;
  logic       timeout_hit;

  // Per-requester operand unpacking and ready decode.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_x_arr[gi] = req_x[8*gi +: 8];
      assign req_y_arr[gi] = req_y[8*gi +: 8];
      assign req_ready[gi] = handshake && (grant_id == 1'(gi));
    end
  endgenerate

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    grant_id = ptr_reg;
    if (req_valid == 2'b01) begin
      grant_id = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end
  end

  // Ready follows valid directly, so any valid request in IDLE is a handshake.
  assign handshake   = (state_reg == S_IDLE) && (req_valid != 2'b00);
  assign timeout_hit = (cnt_reg == TMAX);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (handshake) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (eng_done || timeout_hit) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ptr_reg   <= 1'b0;
      cnt_reg   <= 8'd0;
      x_reg     <= 8'd0;
      y_reg     <= 8'd0;
      id_reg    <= 1'b0;
      data_reg  <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (handshake) begin
            x_reg   <= req_x_arr[grant_id];
            y_reg   <= req_y_arr[grant_id];
            id_reg  <= grant_id;
            ptr_reg <= ~grant_id;
          end
        end
        S_ISSUE: cnt_reg <= 8'd0;
        S_WAIT: begin
          // A completion on the timeout cycle still counts as success.
          if (eng_done) begin
            data_reg <= eng_result;
            err_reg  <= 1'b0;
          end else if (timeout_hit) begin
            data_reg <= 8'hFF;
            err_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_start = (state_reg == S_ISSUE);
  assign eng_x     = x_reg;
  assign eng_y     = y_reg;
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_id    = id_reg;
  assign rsp_data  = data_reg;
  assign rsp_err   = err_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mag_arb_sched.sv
// Bench for mag_arb_sched: an engine model plus a transaction-level reference
// model compared against the DUT every cycle, and directed scenarios with
// hand-computed expectations.
module tb_mag_arb_sched;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_x = 16'd0;
  logic [15:0] req_y = 16'd0;
  logic [1:0]  req_ready;
  logic        eng_start;
  logic [7:0]  eng_x;
  logic [7:0]  eng_y;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_result = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;

  mag_arb_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] isqrt(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return 8'(r);
  endfunction

  function automatic int pick(input logic [1:0] v, input int p);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return p;
  endfunction

  // Environment knobs written by the stimulus process only.
  int         eng_delay    = 12;   // 0 = engine never answers
  int         res_override = -1;   // >=0 replaces the engine answer
  int         stray_req    = 0;    // bump to inject one stray eng_done
  logic [7:0] stray_res    = 8'h00;

  // Observations written by the monitor process only.
  int cyc           = 0;
  int issue_cyc     = -1;
  int first_rsp_cyc = -1;
  int start_cnt     = 0;

  // Monitor: engine model, reference model and per-cycle comparison.
  initial begin
    int         stray_ack;
    int         eng_target;
    logic [7:0] eng_res;
    logic       prev_rv;
    logic       stray;
    logic       mdl_ok;
    int         m_phase;      // 0 idle, 1 launching, 2 waiting, 3 responding
    int         m_ptr;
    int         m_issue;
    int         g;
    logic [7:0] m_x, m_y, m_data;
    logic       m_id, m_err;
    logic [1:0] exp_rdy;
    stray_ack = 0; eng_target = -1; eng_res = 8'd0; prev_rv = 1'b0; mdl_ok = 1'b0;
    m_phase = 0; m_ptr = 0; m_issue = 0;
    m_x = 8'd0; m_y = 8'd0; m_data = 8'd0; m_id = 1'b0; m_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mdl_ok) begin
        exp_rdy = 2'b00;
        if (m_phase == 0 && req_valid != 2'b00) exp_rdy[pick(req_valid, m_ptr)] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("eng_start", eng_start, m_phase == 1);
        check("eng_x", eng_x, m_x);
        check("eng_y", eng_y, m_y);
        check("rsp_valid", rsp_valid, m_phase == 3);
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
        check("rsp_err", rsp_err, m_err);
        check("busy", busy, m_phase != 0);
      end
      if (rsp_valid === 1'b1 && !prev_rv) first_rsp_cyc = cyc;
      prev_rv = (rsp_valid === 1'b1);

      // Engine: answers eng_delay cycles after the launch cycle.
      if (eng_start === 1'b1) begin
        start_cnt++;
        issue_cyc  = cyc;
        eng_target = (eng_delay > 0) ? cyc + eng_delay : -1;
        eng_res    = (res_override >= 0) ? 8'(res_override) : isqrt(int'(m_x), int'(m_y));
      end
      stray      = (stray_req != stray_ack);
      stray_ack  = stray_req;
      eng_done   = stray || (cyc == eng_target);
      eng_result = stray ? stray_res : eng_res;

      // Reference model step, using the inputs seen by the coming edge.
      if (rst) begin
        mdl_ok = 1'b1; m_phase = 0; m_ptr = 0;
        m_x = 8'd0; m_y = 8'd0; m_id = 1'b0; m_data = 8'd0; m_err = 1'b0;
      end else begin
        case (m_phase)
          0: if (req_valid != 2'b00) begin
               g = pick(req_valid, m_ptr);
               m_x = req_x[g*8 +: 8];
               m_y = req_y[g*8 +: 8];
               m_id = g[0];
               m_ptr = 1 - g;
               m_phase = 1;
             end
          1: begin m_issue = cyc; m_phase = 2; end
          2: if (eng_done) begin
               m_data = eng_result; m_err = 1'b0; m_phase = 3;
             end else if (cyc - m_issue == TIMEOUT) begin
               m_data = 8'hFF; m_err = 1'b1; m_phase = 3;
             end
          default: if (rsp_ready) m_phase = 0;
        endcase
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Present one request for one cycle; the DUT must be in IDLE.
  task automatic issue(input logic [1:0] v, input logic [15:0] x, input logic [15:0] y);
    @(posedge clk); #1;
    req_valid = v; req_x = x; req_y = y;
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (rsp_valid !== 1'b1 && n < 200);
    check("rsp_wait", rsp_valid, 1'b1);
  endtask

  initial begin
    int s0;
    logic sid;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_eng_x", eng_x, 8'd0);
    check("rst_rsp_data", rsp_data, 8'd0);

    // Single request: 3,4 -> 5 after 12 engine cycles.
    s0 = start_cnt;
    eng_delay = 12;
    issue(2'b01, 16'h0003, 16'h0004);
    wait_rsp();
    check("single_latency", first_rsp_cyc - issue_cyc, 13);
    check("single_id", rsp_id, 1'b0);
    check("single_data", rsp_data, 8'd5);
    check("single_err", rsp_err, 1'b0);
    check("single_starts", start_cnt - s0, 1);
    $display("[TB] single: id=%0d data=%0d err=%0d", rsp_id, rsp_data, rsp_err);

    // Contention from reset: r0 (6,8)=10, r1 (5,12)=13, grants 0,1,0,1.
    do_reset();
    @(posedge clk); #1;
    req_x = {8'd5, 8'd6}; req_y = {8'd12, 8'd8}; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_rsp();
      check("cont_id", rsp_id, i % 2);
      check("cont_data", rsp_data, (i % 2 == 0) ? 8'd10 : 8'd13);
      $display("[TB] contention rsp %0d: id=%0d data=%0d", i, rsp_id, rsp_data);
    end
    @(posedge clk); #1 req_valid = 2'b00;

    // Timeout: engine silent, then a completion exactly on the timeout cycle.
    eng_delay = 0;
    issue(2'b10, 16'h0700, 16'h0000);
    wait_rsp();
    check("to_latency", first_rsp_cyc - issue_cyc, TIMEOUT + 1);
    check("to_data", rsp_data, 8'hFF);
    check("to_err", rsp_err, 1'b1);
    $display("[TB] timeout: data=%0h err=%0d", rsp_data, rsp_err);
    eng_delay = TIMEOUT; res_override = 8'h2A;
    issue(2'b10, 16'h0700, 16'h0000);
    wait_rsp();
    check("coinc_latency", first_rsp_cyc - issue_cyc, TIMEOUT + 1);
    check("coinc_data", rsp_data, 8'h2A);
    check("coinc_err", rsp_err, 1'b0);
    $display("[TB] coincident done: data=%0h err=%0d", rsp_data, rsp_err);
    res_override = -1;

    // Backpressure: both requesters give 29; response held for 20+ cycles.
    eng_delay = 5;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_x = {8'd21, 8'd20}; req_y = {8'd20, 8'd21}; req_valid = 2'b11;
    wait_rsp();
    sid = rsp_id;
    s0  = start_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i == 7) begin stray_res = 8'h77; stray_req++; end
      @(negedge clk); #1;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_id", rsp_id, sid);
      check("bp_data", rsp_data, 8'd29);
      check("bp_err", rsp_err, 1'b0);
      check("bp_ready", req_ready, 2'b00);
    end
    check("bp_starts", start_cnt - s0, 0);
    $display("[TB] backpressure: id=%0d data=%0d held", rsp_id, rsp_data);
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 2'b00;

    // Reset at WAIT cycle 5; the engine answers later and must be ignored.
    eng_delay = 15;
    @(posedge clk); #1;
    issue(2'b01, 16'h0001, 16'h0001);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (eng_start !== 1'b1 && n < 20);
    check("mid_start_seen", eng_start, 1'b1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("mid_busy", busy, 1'b0);
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_eng_x", eng_x, 8'd0);
    check("mid_rsp_err", rsp_err, 1'b0);
    repeat (12) @(negedge clk);
    #1;
    check("late_busy", busy, 1'b0);
    check("late_rsp_valid", rsp_valid, 1'b0);
    eng_delay = 4;
    issue(2'b11, {8'd1, 8'd9}, {8'd1, 8'd12});
    wait_rsp();
    check("post_rst_id", rsp_id, 1'b0);
    check("post_rst_data", rsp_data, 8'd15);
    check("post_rst_latency", first_rsp_cyc - issue_cyc, 5);
    $display("[TB] after reset: id=%0d data=%0d", rsp_id, rsp_data);

    // Stray completion while idle.
    repeat (3) @(posedge clk);
    #1 stray_res = 8'h55; stray_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("stray_rsp_valid", rsp_valid, 1'b0);
      check("stray_busy", busy, 1'b0);
    end
    $display("[TB] stray idle done: busy=%0d", busy);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
